// File: rtl/lights_out_grid.sv
// Lights-out puzzle: LFSR scramble, then player presses toggle a cell and its neighbours.
// Latency: every press is visible one cycle after the strobe. No backpressure: presses outside PLAY are dropped.
module lights_out_grid #(
    parameter int          ROWS         = 3,
    parameter int          COLS         = 3,
    parameter int          WRAP         = 0,
    parameter int          MOVE_W       = 8,
    parameter int          SCRAMBLE_CYC = 32,
    parameter logic [15:0] SEED         = 16'hACE1,
    localparam int         N            = ROWS * COLS,
    localparam int         IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              btn_valid,
    input  logic [IDX_W-1:0]  btn_idx,
    input  logic              new_game,
    output logic [N-1:0]      field,
    output logic [MOVE_W-1:0] moves,
    output logic              busy,
    output logic              solved
);
    localparam int CNT_W = (SCRAMBLE_CYC > 0) ? $clog2(SCRAMBLE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCRAMBLE_CYC);

    typedef enum logic [1:0] {SCRAMBLE, PLAY, WON} state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [CNT_W-1:0]  cnt;
    logic              lfsr_fb;
    logic [IDX_W-1:0]  syn_idx;
    logic              btn_ok;
    logic              syn_ok;
    logic [N-1:0]      btn_mask;
    logic [N-1:0]      syn_mask;
    logic [N-1:0]      post_press;

    // OR-ing the targets means wrapped duplicates still toggle each cell once.
    function automatic logic [N-1:0] cell_mask(input int r, input int c);
        logic [N-1:0] m;
        m = N'(1) << (r * COLS + c);
        if (WRAP != 0) begin
            m |= N'(1) << (((r + 1) % ROWS) * COLS + c);
            m |= N'(1) << (((r + ROWS - 1) % ROWS) * COLS + c);
            m |= N'(1) << (r * COLS + (c + 1) % COLS);
            m |= N'(1) << (r * COLS + (c + COLS - 1) % COLS);
        end else begin
            if (r > 0)        m |= N'(1) << ((r - 1) * COLS + c);
            if (r < ROWS - 1) m |= N'(1) << ((r + 1) * COLS + c);
            if (c > 0)        m |= N'(1) << (r * COLS + c - 1);
            if (c < COLS - 1) m |= N'(1) << (r * COLS + c + 1);
        end
        return m;
    endfunction

    function automatic logic [N-1:0] press_mask(input logic [IDX_W-1:0] idx);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(idx) == r * COLS + c) m = cell_mask(r, c);
            end
        end
        return m;
    endfunction

    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign syn_idx    = lfsr[IDX_W-1:0];
    assign btn_ok     = btn_valid && (int'(btn_idx) < N);
    assign syn_ok     = int'(syn_idx) < N;
    assign btn_mask   = press_mask(btn_idx);
    assign syn_mask   = press_mask(syn_idx);
    assign post_press = field ^ btn_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field  <= '0;
            moves  <= '0;
            lfsr   <= SEED;
            state  <= SCRAMBLE;
            cnt    <= CNT_LOAD;
            busy   <= 1'b1;
            solved <= 1'b0;
        end else if (ena) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (new_game) begin
                moves  <= '0;
                state  <= SCRAMBLE;
                cnt    <= CNT_LOAD;
                busy   <= 1'b1;
                solved <= 1'b0;
            end else begin
                case (state)
                    SCRAMBLE: begin
                        // A zero count means an empty scramble: one idle cycle, then PLAY.
                        if (cnt != '0) begin
                            if (syn_ok) field <= field ^ syn_mask;
                            cnt <= cnt - CNT_W'(1);
                        end
                        if (cnt <= CNT_W'(1)) begin
                            state <= PLAY;
                            busy  <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (btn_ok) begin
                            field <= post_press;
                            if (moves != '1) moves <= moves + MOVE_W'(1);
                            if (post_press == '0) begin
                                state  <= WON;
                                solved <= 1'b1;
                            end
                        end
                    end
                    WON: ;
                    default: begin
                        state <= SCRAMBLE;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lights_out_grid.sv
// Bench: three 3x3 instances (edge/SC=0, wrap+2-bit moves/SC=0, edge/SC=32) against a cell-level reference model.
module tb_lights_out_grid;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rn[3], en[3], bv[3], ng[3];
    logic [3:0] bi[3];
    logic [8:0] f0, f1, f2;
    logic [7:0] mv0, mv2;
    logic [1:0] mv1;
    logic       bz0, bz1, bz2, sv0, sv1, sv2;

    int n_vec = 0;
    int n_bad = 0;

    localparam int SCR = 0, PLY = 1, WON = 2;
    int          cfg_wrap[3] = '{0, 1, 0};
    int          cfg_max[3]  = '{255, 3, 255};
    int          cfg_sc[3]   = '{0, 0, 32};
    logic [8:0]  m_field[3];
    int          m_moves[3];
    logic [15:0] m_lfsr[3];
    int          m_mode[3];
    int          m_cnt[3];
    logic [8:0]  board1, board2;

    lights_out_grid #(.ROWS(3), .COLS(3), .WRAP(0), .MOVE_W(8), .SCRAMBLE_CYC(0)) u0 (
        .clk(clk), .rst_n(rn[0]), .ena(en[0]), .btn_valid(bv[0]), .btn_idx(bi[0]),
        .new_game(ng[0]), .field(f0), .moves(mv0), .busy(bz0), .solved(sv0));
    lights_out_grid #(.ROWS(3), .COLS(3), .WRAP(1), .MOVE_W(2), .SCRAMBLE_CYC(0)) u1 (
        .clk(clk), .rst_n(rn[1]), .ena(en[1]), .btn_valid(bv[1]), .btn_idx(bi[1]),
        .new_game(ng[1]), .field(f1), .moves(mv1), .busy(bz1), .solved(sv1));
    lights_out_grid #(.ROWS(3), .COLS(3), .WRAP(0), .MOVE_W(8), .SCRAMBLE_CYC(32)) u2 (
        .clk(clk), .rst_n(rn[2]), .ena(en[2]), .btn_valid(bv[2]), .btn_idx(bi[2]),
        .new_game(ng[2]), .field(f2), .moves(mv2), .busy(bz2), .solved(sv2));

    // Toggle each distinct in-grid target of a press exactly once.
    function automatic logic [8:0] press(input logic [8:0] f, input int idx, input int wrap);
        int rr[5];
        int cc[5];
        int q[$];
        int r, c;
        r  = idx / 3;
        c  = idx % 3;
        rr = '{r, r - 1, r + 1, r, r};
        cc = '{c, c, c, c - 1, c + 1};
        for (int k = 0; k < 5; k++) begin
            int a, b, t;
            bit dup;
            a = rr[k];
            b = cc[k];
            if (wrap != 0) begin
                a = (a + 3) % 3;
                b = (b + 3) % 3;
            end else if (a < 0 || a > 2 || b < 0 || b > 2) begin
                continue;
            end
            t   = a * 3 + b;
            dup = 1'b0;
            foreach (q[j]) if (q[j] == t) dup = 1'b1;
            if (!dup) q.push_back(t);
        end
        foreach (q[j]) f[q[j]] = ~f[q[j]];
        return f;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return 16'(((int'(l) * 2) % 65536) + fb);
    endfunction

    task automatic model_step(input int d);
        int syn;
        if (!rn[d]) begin
            m_field[d] = '0;
            m_moves[d] = 0;
            m_lfsr[d]  = 16'hACE1;
            m_mode[d]  = SCR;
            m_cnt[d]   = cfg_sc[d];
        end else if (en[d]) begin
            syn       = int'(m_lfsr[d]) % 16;
            m_lfsr[d] = lfsr_next(m_lfsr[d]);
            if (ng[d]) begin
                m_moves[d] = 0;
                m_mode[d]  = SCR;
                m_cnt[d]   = cfg_sc[d];
            end else if (m_mode[d] == SCR) begin
                if (m_cnt[d] > 0) begin
                    if (syn < 9) m_field[d] = press(m_field[d], syn, cfg_wrap[d]);
                    m_cnt[d]--;
                end
                if (m_cnt[d] == 0) m_mode[d] = PLY;
            end else if (m_mode[d] == PLY && bv[d] && int'(bi[d]) < 9) begin
                m_field[d] = press(m_field[d], int'(bi[d]), cfg_wrap[d]);
                if (m_moves[d] < cfg_max[d]) m_moves[d]++;
                if (m_field[d] == '0) m_mode[d] = WON;
            end
        end
    endtask

    task automatic cycle();
        for (int d = 0; d < 3; d++) model_step(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [18:0] obs(input int d);
        case (d)
            0:       return {f0, mv0, bz0, sv0};
            1:       return {f1, 6'b0, mv1, bz1, sv1};
            default: return {f2, mv2, bz2, sv2};
        endcase
    endfunction

    function automatic logic [18:0] expv(input int d);
        return {m_field[d], 8'(m_moves[d]), m_mode[d] == SCR, m_mode[d] == WON};
    endfunction

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin rn[d] = 1'b0; en[d] = 1'b0; end
        cycle();
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs(d) !== {9'b0, 8'b0, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_u%0d got {field,moves,busy,solved}=%h want %h", d, obs(d), {9'b0, 8'b0, 1'b1, 1'b0});
            end
            rn[d] = 1'b1;
        end
    endtask

    task automatic test_center_press();
        en[0] = 1'b1;
        cycle();
        n_vec++;
        if (bz0 !== 1'b0 || f0 !== 9'b0) begin
            n_bad++; $display("FAIL empty_scramble busy=%b field=%b want 0/000000000", bz0, f0);
        end
        bv[0] = 1'b1; bi[0] = 4'd4;
        cycle();
        n_vec++;
        if (f0 !== 9'b010111010 || mv0 !== 8'd1) begin
            n_bad++; $display("FAIL center_press field=%b moves=%0d want 010111010/1", f0, mv0);
        end
        cycle();
        n_vec++;
        if (f0 !== 9'b0 || sv0 !== 1'b1 || mv0 !== 8'd2) begin
            n_bad++; $display("FAIL center_solve field=%b solved=%b moves=%0d want 0/1/2", f0, sv0, mv0);
        end
        bv[0] = 1'b0;
    endtask

    task automatic test_won_freeze();
        bv[0] = 1'b1; bi[0] = 4'd1;
        cycle();
        n_vec++;
        if (obs(0) !== {9'b0, 8'd2, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL won_freeze got %h want %h", obs(0), {9'b0, 8'd2, 1'b0, 1'b1});
        end
        bv[0] = 1'b0;
    endtask

    task automatic test_corner_and_range();
        ng[0] = 1'b1;
        cycle();
        n_vec++;
        if (mv0 !== 8'd0 || bz0 !== 1'b1 || sv0 !== 1'b0 || f0 !== 9'b0) begin
            n_bad++; $display("FAIL new_game_from_won moves=%0d busy=%b solved=%b field=%b", mv0, bz0, sv0, f0);
        end
        ng[0] = 1'b0;
        cycle();
        bv[0] = 1'b1; bi[0] = 4'd0;
        cycle();
        n_vec++;
        if (f0 !== 9'b000001011 || mv0 !== 8'd1) begin
            n_bad++; $display("FAIL corner_edge field=%b moves=%0d want 000001011/1", f0, mv0);
        end
        bi[0] = 4'd9;
        cycle();
        n_vec++;
        if (f0 !== 9'b000001011 || mv0 !== 8'd1) begin
            n_bad++; $display("FAIL idx9_ignored field=%b moves=%0d want 000001011/1", f0, mv0);
        end
        bi[0] = 4'd15;
        cycle();
        n_vec++;
        if (f0 !== 9'b000001011 || mv0 !== 8'd1) begin
            n_bad++; $display("FAIL idx15_ignored field=%b moves=%0d want 000001011/1", f0, mv0);
        end
        bv[0] = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        en[1] = 1'b1;
        cycle();
        bv[1] = 1'b1; bi[1] = 4'd0;
        cycle();
        n_vec++;
        if (f1 !== 9'b001001111 || mv1 !== 2'd1) begin
            n_bad++; $display("FAIL wrap_corner field=%b moves=%0d want 001001111/1", f1, mv1);
        end
        for (int i = 1; i <= 4; i++) begin
            bi[1] = 4'(i);
            cycle();
            n_vec++;
            if (obs(1) !== expv(1)) begin
                n_bad++; $display("FAIL wrap_press_%0d got %h want %h", i, obs(1), expv(1));
            end
        end
        n_vec++;
        if (mv1 !== 2'd3 || sv1 !== 1'b0) begin
            n_bad++; $display("FAIL moves_saturate moves=%0d solved=%b want 3/0", mv1, sv1);
        end
        bv[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            en[0] = ($urandom % 8) != 0;
            bv[0] = ($urandom % 4) != 0;
            bi[0] = 4'($urandom_range(0, 15));
            ng[0] = ($urandom % 16) == 0;
            cycle();
            n_vec++;
            if (obs(0) !== expv(0)) begin
                n_bad++; $display("FAIL back_to_back_%0d got %h want %h", i, obs(0), expv(0));
            end
        end
        en[0] = 1'b0; bv[0] = 1'b0; ng[0] = 1'b0;
    endtask

    // Runs u2 from a fresh reset until 32 enabled cycles have elapsed.
    task automatic test_scramble(output logic [8:0] board);
        int ena_cnt;
        ena_cnt = 0;
        ng[2]   = 1'b0;
        for (int i = 0; i < 400 && ena_cnt < 32; i++) begin
            en[2] = ($urandom % 4) != 0;
            bv[2] = $urandom % 2;
            bi[2] = 4'($urandom_range(0, 15));
            cycle();
            if (en[2]) ena_cnt++;
            n_vec++;
            if (bz2 !== (ena_cnt < 32) || obs(2) !== expv(2)) begin
                n_bad++;
                $display("FAIL scramble_cyc%0d ena_cnt=%0d busy=%b got %h want %h", i, ena_cnt, bz2, obs(2), expv(2));
            end
        end
        n_vec++;
        if (ena_cnt != 32) begin
            n_bad++; $display("FAIL scramble_timeout ena_cnt=%0d want 32", ena_cnt);
        end
        bv[2]  = 1'b0;
        board  = f2;
    endtask

    task automatic test_new_game_priority();
        logic [8:0] saved;
        en[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bv[2] = 1'b1;
            bi[2] = 4'($urandom_range(0, 8));
            cycle();
            n_vec++;
            if (obs(2) !== expv(2)) begin
                n_bad++; $display("FAIL play_press_%0d got %h want %h", i, obs(2), expv(2));
            end
        end
        saved = f2;
        ng[2] = 1'b1; bv[2] = 1'b1; bi[2] = 4'd4;
        cycle();
        n_vec++;
        if (mv2 !== 8'd0 || bz2 !== 1'b1 || sv2 !== 1'b0 || f2 !== saved) begin
            n_bad++; $display("FAIL new_game_priority moves=%0d busy=%b field=%b want 0/1/%b", mv2, bz2, f2, saved);
        end
        ng[2] = 1'b0; bv[2] = 1'b0;
    endtask

    task automatic test_reset_mid_scramble();
        for (int i = 0; i < 5; i++) cycle();
        n_vec++;
        if (bz2 !== 1'b1 || obs(2) !== expv(2)) begin
            n_bad++; $display("FAIL mid_scramble got %h want %h", obs(2), expv(2));
        end
        rn[2] = 1'b0;
        cycle();
        n_vec++;
        if (obs(2) !== {9'b0, 8'b0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL reset_mid_scramble got %h want %h", obs(2), {9'b0, 8'b0, 1'b1, 1'b0});
        end
        rn[2] = 1'b1;
        test_scramble(board2);
        n_vec++;
        if (board2 !== board1) begin
            n_bad++; $display("FAIL deterministic_board got %b want %b", board2, board1);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rn[d] = 1'b1; en[d] = 1'b0; bv[d] = 1'b0; ng[d] = 1'b0; bi[d] = 4'd0;
            m_field[d] = '0; m_moves[d] = 0; m_lfsr[d] = 16'hACE1; m_mode[d] = SCR; m_cnt[d] = cfg_sc[d];
        end
        @(negedge clk);
        test_reset();
        test_center_press();
        test_won_freeze();
        test_corner_and_range();
        test_wrap_saturate();
        test_back_to_back();
        test_scramble(board1);
        test_new_game_priority();
        test_reset_mid_scramble();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lights_out_grid.md
LIGHTS_OUT_GRID -- requirements
Module: lights_out_grid

Interface
REQ-001 The module SHALL have parameter ROWS, default 3, meaning number of grid rows (1..8).
REQ-002 The module SHALL have parameter COLS, default 3, meaning number of grid columns (1..8).
REQ-003 The module SHALL have parameter WRAP, default 0, meaning 1 = toroidal neighbour wrap and 0 = edges stop.
REQ-004 The module SHALL have parameter MOVE_W, default 8, meaning move-counter width.
REQ-005 The module SHALL have parameter SCRAMBLE_CYC, default 32, meaning scramble length in cycles (0 allowed).
REQ-006 The module SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-008 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 The module SHALL have port ena, input, 1 bit: when 0, all state (field, counters, FSM, LFSR) holds.
REQ-010 The module SHALL have port btn_valid, input, 1 bit: single-cycle press strobe.
REQ-011 The module SHALL have port btn_idx, input, IDX_W = max(1, clog2(ROWS*COLS)) bits: pressed cell index, where idx = row*COLS + col.
REQ-012 The module SHALL have port new_game, input, 1 bit: restart request.
REQ-013 The module SHALL have port field, output, N = ROWS*COLS bits: light state, where bit idx is cell idx and 1 = lit.
REQ-014 The module SHALL have port moves, output, MOVE_W bits: accepted player presses.
REQ-015 The module SHALL have port busy, output, 1 bit: 1 while in state SCRAMBLE.
REQ-016 The module SHALL have port solved, output, 1 bit: 1 while in state WON.

Function
REQ-017 The FSM SHALL have three states, SCRAMBLE, PLAY and WON, and all outputs SHALL be registered.
REQ-018 The toggle mask for cell (r,c) SHALL be the bitwise OR of the cell itself and its orthogonal neighbours.
REQ-019 When WRAP=0, out-of-grid neighbours SHALL be omitted; when WRAP=1, rows and columns SHALL wrap modulo ROWS and COLS.
REQ-020 Duplicate neighbours (ROWS or COLS of 1 or 2 with WRAP) SHALL still toggle each distinct cell exactly once per press.
REQ-021 A press SHALL be applied as field <= field XOR mask, visible the cycle after the strobe.
REQ-022 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting once per cycle while ena=1 in every state.
REQ-023 In SCRAMBLE, each cycle SHALL apply one synthetic press at index = LFSR[IDX_W-1:0].
REQ-024 A synthetic index >= N SHALL be skipped, but the cycle SHALL still count toward the scramble length.
REQ-025 SCRAMBLE SHALL last exactly SCRAMBLE_CYC cycles (a down-counter), then move to PLAY; if SCRAMBLE_CYC=0, SCRAMBLE SHALL last one cycle with no presses applied.
REQ-026 Synthetic presses SHALL NOT increment moves, and player presses SHALL be ignored during SCRAMBLE.
REQ-027 In PLAY, a press SHALL be accepted only when btn_valid=1 and btn_idx < N; an out-of-range press SHALL have no effect.
REQ-028 Each accepted press SHALL increment moves, saturating at 2^MOVE_W-1.
REQ-029 PLAY SHALL go to WON on the cycle the post-press field equals zero; a zero field reached without a player press SHALL NOT trigger WON.
REQ-030 In WON, the field and moves SHALL freeze and presses SHALL be ignored.
REQ-031 new_game=1 in any state SHALL clear moves, keep the field and the running LFSR, and enter SCRAMBLE for SCRAMBLE_CYC cycles.
REQ-032 new_game SHALL take priority over a simultaneous btn_valid.
REQ-033 The net number of toggles from a scramble SHALL be applied only through the press mask, so every generated board is solvable.

Reset
REQ-034 With rst_n=0 at a rising clk edge (regardless of ena), the block SHALL set field=0, moves=0, LFSR=SEED, state=SCRAMBLE, busy=1, solved=0, and scramble counter=SCRAMBLE_CYC.
REQ-035 Reset mid-scramble or mid-game SHALL fully reinitialise the block on the next edge, with no partial press applied.
REQ-036 After release, a given SEED and ena pattern SHALL produce a deterministic board.

Verification
REQ-037 The bench SHALL cover: 3x3, WRAP=0, SCRAMBLE_CYC=0, reset, then press idx 4 -> field=9'b010111010, moves=1; press idx 4 again -> field=0, solved=1, moves=2.
REQ-038 The bench SHALL cover: 3x3, WRAP=0, press idx 0 -> field=9'b000001011; with WRAP=1, press idx 0 -> field=9'b001001111.
REQ-039 The bench SHALL cover: btn_idx=9 on 3x3 in PLAY -> field and moves unchanged; a press in WON -> unchanged.
REQ-040 The bench SHALL cover: MOVE_W=2, five accepted non-solving presses -> moves=3 (saturated).
REQ-041 The bench SHALL cover: SCRAMBLE_CYC=32, reset -> busy=1 for exactly 32 ena cycles; the board matches a reference model; presses during busy are ignored; ena=0 stretches busy.
REQ-042 The bench SHALL cover: new_game with btn_valid in PLAY -> moves=0, busy=1, and the press is not applied; rst_n=0 mid-scramble -> field=0 and the counter is reloaded.
